pi_cmd_rx: RTL and testbench

PI_CMD_RX -- requirements
Module: pi_cmd_rx

---
 rtl/oscope_pkg.sv | 68 ++++++
 rtl/sync_bit.sv | 24 ++
 rtl/pi_cmd_rx.sv | 160 ++++++++++++++++
 tb/tb_pi_cmd_rx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oscope_pkg.sv
// Shared oscilloscope definitions: command opcodes, control-register reset
// defaults, the Pi command receiver state encoding and its frame decoder.
package oscope_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned CNT_SAT    = 17;

    localparam logic [BYTE_W-1:0] OP_REARM     = 8'h01;
    localparam logic [BYTE_W-1:0] OP_SET_DECIM = 8'h02;
    localparam logic [BYTE_W-1:0] OP_SET_TRIG  = 8'h03;
    localparam logic [BYTE_W-1:0] OP_SET_MODE  = 8'h04;

    localparam logic [BYTE_W-1:0] DECIM_RST      = 8'h01;
    localparam logic [BYTE_W-1:0] TRIG_LEVEL_RST = 8'h80;
    localparam logic [1:0]        TRIG_MODE_RST  = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EXEC  = 2'd2
    } state_t;

    typedef struct packed {
        logic [BYTE_W-1:0] opcode;
        logic [BYTE_W-1:0] arg;
    } cmd_t;

    typedef struct packed {
        logic ok;
        logic rearm;
        logic set_decim;
        logic set_trig;
        logic set_mode;
    } dec_t;

    // Classify a received frame; anything not fully valid yields ok = 0.
    function automatic dec_t decode_cmd(input cmd_t cmd, input logic [CNT_W-1:0] cnt);
        dec_t d;
        d = '0;
        if (cnt == CNT_W'(FRAME_BITS)) begin
            case (cmd.opcode)
                OP_REARM: begin
                    d.ok    = 1'b1;
                    d.rearm = 1'b1;
                end
                OP_SET_DECIM: begin
                    if (cmd.arg != '0) begin
                        d.ok        = 1'b1;
                        d.set_decim = 1'b1;
                    end
                end
                OP_SET_TRIG: begin
                    d.ok       = 1'b1;
                    d.set_trig = 1'b1;
                end
                OP_SET_MODE: begin
                    d.ok       = 1'b1;
                    d.set_mode = 1'b1;
                end
                default: d = '0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with configurable depth and reset value.
module sync_bit #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {DEPTH{RST_VAL}};
        end else begin
            chain <= DEPTH'({chain, d});
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/pi_cmd_rx.sv
// Receives 16-bit SPI-style command frames from the Pi in the osc_clk domain,
// returns a status byte on MISO and drives the capture control registers.
module pi_cmd_rx
    import oscope_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       osc_clk,
    input  logic       reset_n,
    input  logic       pi_cs_n,
    input  logic       pi_sclk,
    input  logic       pi_mosi,
    input  logic [7:0] status,
    output logic       pi_miso,
    output logic       rearm,
    output logic [7:0] decim,
    output logic [7:0] trig_level,
    output logic [1:0] trig_mode,
    output logic       cmd_valid,
    output logic       cmd_error
);

    localparam int unsigned SETTLE_W = (SYNC_STAGES < 2) ? 1 : $clog2(SYNC_STAGES + 1);

    logic cs_s, sclk_s, mosi_s;
    logic cs_q, sclk_q;
    logic armed;
    logic [SETTLE_W-1:0] settle_cnt;
    logic settled;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    state_t state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [FRAME_BITS-1:0] sr, sr_d;
    logic [BYTE_W-1:0]     miso_sr, miso_sr_d;
    logic                  pi_miso_d, rearm_d, cmd_valid_d, cmd_error_d;
    logic [BYTE_W-1:0]     decim_d, trig_level_d;
    logic [1:0]            trig_mode_d;
    cmd_t                  cmd;
    dec_t                  dec;

    sync_bit #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(osc_clk), .rst_n(reset_n), .d(pi_cs_n), .q(cs_s)
    );
    sync_bit #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(osc_clk), .rst_n(reset_n), .d(pi_sclk), .q(sclk_s)
    );
    sync_bit #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(osc_clk), .rst_n(reset_n), .d(pi_mosi), .q(mosi_s)
    );

    // cs_n only arms once a genuine high level has flushed through the
    // synchronizer, so a frame already running at reset release is ignored.
    assign settled   = (settle_cnt == SETTLE_W'(SYNC_STAGES));
    assign cs_fall   = armed & cs_q & ~cs_s;
    assign cs_rise   = ~cs_q & cs_s;
    assign sclk_rise = ~sclk_q & sclk_s;
    assign sclk_fall = sclk_q & ~sclk_s;

    assign cmd = cmd_t'(sr);
    assign dec = decode_cmd(cmd, cnt);

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            armed      <= 1'b0;
            settle_cnt <= '0;
        end else begin
            cs_q       <= cs_s;
            sclk_q     <= sclk_s;
            armed      <= armed | (settled & cs_s);
            settle_cnt <= settled ? settle_cnt : settle_cnt + SETTLE_W'(1);
        end
    end

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            miso_sr    <= '0;
            pi_miso    <= 1'b0;
            rearm      <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_error  <= 1'b0;
            decim      <= DECIM_RST;
            trig_level <= TRIG_LEVEL_RST;
            trig_mode  <= TRIG_MODE_RST;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sr         <= sr_d;
            miso_sr    <= miso_sr_d;
            pi_miso    <= pi_miso_d;
            rearm      <= rearm_d;
            cmd_valid  <= cmd_valid_d;
            cmd_error  <= cmd_error_d;
            decim      <= decim_d;
            trig_level <= trig_level_d;
            trig_mode  <= trig_mode_d;
        end
    end

    // Pulses are registered on the cs_n rise so they appear during EXEC;
    // control registers commit on the EXEC edge and are visible one cycle later.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        sr_d         = sr;
        miso_sr_d    = miso_sr;
        rearm_d      = 1'b0;
        cmd_valid_d  = 1'b0;
        cmd_error_d  = 1'b0;
        decim_d      = decim;
        trig_level_d = trig_level;
        trig_mode_d  = trig_mode;

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    miso_sr_d = status;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d     = EXEC;
                    cmd_valid_d = dec.ok;
                    cmd_error_d = ~dec.ok;
                    rearm_d     = dec.rearm;
                end else begin
                    if (sclk_rise) begin
                        sr_d  = {sr[FRAME_BITS-2:0], mosi_s};
                        cnt_d = (cnt == CNT_W'(CNT_SAT)) ? cnt : cnt + CNT_W'(1);
                    end
                    if (sclk_fall) begin
                        miso_sr_d = {miso_sr[BYTE_W-2:0], 1'b0};
                    end
                end
            end
            EXEC: begin
                state_d = IDLE;
                if (dec.set_decim) decim_d      = cmd.arg;
                if (dec.set_trig)  trig_level_d = cmd.arg;
                if (dec.set_mode)  trig_mode_d  = cmd.arg[1:0];
                if (cs_fall) begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    miso_sr_d = status;
                end
            end
            default: state_d = IDLE;
        endcase

        pi_miso_d = (state_d == SHIFT) & miso_sr_d[BYTE_W-1];
    end

endmodule

// File: tb/tb_pi_cmd_rx.sv
// Scoreboard bench for pi_cmd_rx: directed and random Pi frames against a
// frame-level behavioural model, with an independent response monitor.
module tb_pi_cmd_rx;

    localparam int H = 5;

    logic       osc_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pi_cs_n = 1'b1;
    logic       pi_sclk = 1'b0;
    logic       pi_mosi = 1'b0;
    logic [7:0] status  = 8'h00;
    logic       pi_miso, rearm, cmd_valid, cmd_error;
    logic [7:0] decim, trig_level;
    logic [1:0] trig_mode;

    pi_cmd_rx #(.SYNC_STAGES(2)) dut (
        .osc_clk(osc_clk), .reset_n(reset_n), .pi_cs_n(pi_cs_n), .pi_sclk(pi_sclk),
        .pi_mosi(pi_mosi), .status(status), .pi_miso(pi_miso), .rearm(rearm),
        .decim(decim), .trig_level(trig_level), .trig_mode(trig_mode),
        .cmd_valid(cmd_valid), .cmd_error(cmd_error)
    );

    always #5 osc_clk = ~osc_clk;

    typedef struct {
        logic       valid;
        logic       error;
        logic       rearm;
        logic [7:0] decim;
        logic [7:0] trig_level;
        logic [1:0] trig_mode;
    } exp_t;

    exp_t       sb[$];
    exp_t       pend, got_e;
    bit         chk_next = 1'b0;
    int         checks = 0, errors = 0;
    int         valid_seen = 0, pulse_seen = 0, valid_exp = 0;
    logic [7:0] m_decim = 8'h01, m_trig = 8'h80;
    logic [1:0] m_mode = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge osc_clk);
    endtask

    // Frame-level model: a command is only accepted as exactly 16 bits.
    function automatic void model_frame(input logic [31:0] bits, input int n);
        exp_t       e;
        logic [7:0] op, arg;
        e.valid = 1'b0;
        e.rearm = 1'b0;
        if (n == 16) begin
            op  = bits[15:8];
            arg = bits[7:0];
            if (op == 8'd1) begin e.valid = 1'b1; e.rearm = 1'b1; end
            else if (op == 8'd2 && arg != 8'd0) begin e.valid = 1'b1; m_decim = arg; end
            else if (op == 8'd3) begin e.valid = 1'b1; m_trig = arg; end
            else if (op == 8'd4) begin e.valid = 1'b1; m_mode = arg[1:0]; end
        end
        e.error      = !e.valid;
        e.decim      = m_decim;
        e.trig_level = m_trig;
        e.trig_mode  = m_mode;
        if (e.valid) valid_exp++;
        sb.push_back(e);
    endfunction

    function automatic void model_reset();
        m_decim = 8'h01;
        m_trig  = 8'h80;
        m_mode  = 2'b00;
    endfunction

    // Response monitor: pops one expectation per pulse, checks registers a cycle later.
    always @(negedge osc_clk) begin
        if (!reset_n) begin
            chk_next = 1'b0;
        end else begin
            if (chk_next) begin
                check("decim_after_cmd", 32'(decim), 32'(pend.decim));
                check("trig_level_after_cmd", 32'(trig_level), 32'(pend.trig_level));
                check("trig_mode_after_cmd", 32'(trig_mode), 32'(pend.trig_mode));
                chk_next = 1'b0;
            end
            if (cmd_valid || cmd_error || rearm) begin
                pulse_seen++;
                if (cmd_valid) valid_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: valid=%0b error=%0b rearm=%0b with none expected",
                             cmd_valid, cmd_error, rearm);
                end else begin
                    got_e = sb.pop_front();
                    check("valid_error_exclusive", 32'(cmd_valid & cmd_error), 32'(0));
                    check("cmd_valid", 32'(cmd_valid), 32'(got_e.valid));
                    check("cmd_error", 32'(cmd_error), 32'(got_e.error));
                    check("rearm", 32'(rearm), 32'(got_e.rearm));
                    pend     = got_e;
                    chk_next = 1'b1;
                end
            end
        end
    end

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            tick(1);
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses still pending", sb.size());
            sb.delete();
        end
        tick(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pi_miso"}, 32'(pi_miso), 32'(0));
        check({tag, "_rearm"}, 32'(rearm), 32'(0));
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'(0));
        check({tag, "_cmd_error"}, 32'(cmd_error), 32'(0));
        check({tag, "_decim"}, 32'(decim), 32'h01);
        check({tag, "_trig_level"}, 32'(trig_level), 32'h80);
        check({tag, "_trig_mode"}, 32'(trig_mode), 32'h0);
    endtask

    // Mode-0 frame: MOSI set while sclk low, MISO sampled just before each rise.
    task automatic send_frame(input logic [31:0] bits, input int n, input logic [7:0] st,
                              input bit short_gap);
        status  = st;
        pi_cs_n = 1'b0;
        tick(H);
        for (int i = 0; i < n; i++) begin
            pi_mosi = bits[n-1-i];
            tick(H);
            check($sformatf("miso_bit%0d", i), 32'(pi_miso), (i < 8) ? 32'(st[7-i]) : 32'(0));
            pi_sclk = 1'b1;
            tick(H);
            pi_sclk = 1'b0;
        end
        model_frame(bits, n);
        tick(H);
        pi_cs_n = 1'b1;
        if (short_gap) begin
            tick(1);
        end else begin
            tick(4 * H);
            check("miso_idle", 32'(pi_miso), 32'(0));
            drain();
        end
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        tick(2);
        check_reset_outputs("reset_idle");
        model_reset();
        reset_n = 1'b1;
        tick(8);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int         p0, v0, sel, n;
        logic [7:0] op, arg;
        logic [31:0] bits;

        tick(3);
        check_reset_outputs("reset_start");
        reset_n = 1'b1;
        tick(8);

        send_frame(32'h0204, 16, 8'h3C, 1'b0);
        check("decim_set_4", 32'(decim), 32'h04);

        send_frame(32'h01FF, 16, 8'hA5, 1'b0);

        send_frame(32'h034, 12, 8'h5A, 1'b0);
        check("trig_level_after_short", 32'(trig_level), 32'h80);

        reset_pulse();
        send_frame(32'h0733, 16, 8'h00, 1'b0);
        send_frame(32'h0200, 16, 8'hFF, 1'b0);
        send_frame({15'h0, 16'h0205, 1'b1}, 17, 8'h81, 1'b0);
        check("decim_after_rejects", 32'(decim), 32'h01);

        v0 = valid_seen;
        send_frame(32'h0403, 16, 8'h12, 1'b1);
        send_frame(32'h0310, 16, 8'h34, 1'b0);
        check("b2b_trig_mode", 32'(trig_mode), 32'h3);
        check("b2b_trig_level", 32'(trig_level), 32'h10);
        check("b2b_valid_count", 32'(valid_seen - v0), 32'd2);

        // Reset part way into a 0x02,0x08 frame, then release with cs_n still low.
        status  = 8'hC3;
        pi_cs_n = 1'b0;
        tick(H);
        bits = 32'h0208;
        for (int i = 0; i < 9; i++) begin
            pi_mosi = bits[15-i];
            tick(H);
            pi_sclk = 1'b1;
            tick(H);
            pi_sclk = 1'b0;
        end
        reset_n = 1'b0;
        tick(2);
        check_reset_outputs("reset_mid");
        model_reset();
        p0 = pulse_seen;
        reset_n = 1'b1;
        tick(10);
        for (int i = 0; i < 3; i++) begin
            pi_sclk = 1'b1;
            tick(H);
            pi_sclk = 1'b0;
            tick(H);
        end
        pi_cs_n = 1'b1;
        tick(20);
        check("no_pulse_after_reset", 32'(pulse_seen - p0), 32'd0);
        check("decim_after_reset_mid", 32'(decim), 32'h01);
        send_frame(32'h0208, 16, 8'h99, 1'b0);
        check("decim_clean_frame", 32'(decim), 32'h08);

        for (int f = 0; f < 30; f++) begin
            sel = $urandom_range(0, 6);
            arg = 8'($urandom);
            case (sel)
                0, 1, 2, 3: op = 8'(sel + 1);
                4:          op = 8'($urandom);
                5: begin op = 8'h02; arg = 8'h00; end
                default:    op = 8'h03;
            endcase
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 20) : 16;
            bits = $urandom;
            if (n >= 16) bits[n-1 -: 16] = {op, arg};
            if (n < 32) bits = bits & ((32'd1 << n) - 32'd1);
            send_frame(bits, n, 8'($urandom), ($urandom_range(0, 3) == 0));
        end
        tick(4 * H);
        drain();

        check("total_valid_count", 32'(valid_seen), 32'(valid_exp));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
